individual_eval_ctrl: RTL

- Sequences fitness evaluation of one combinational evolved individual: four 16-bit operands in (a1, a0, b1, b0), four 16-bit results out (y3..y0).
- Accepts test vectors with expected results over a valid/ready stream and drives them onto the individual.
- Waits a settle window, compares outputs word-by-word, and accumulates a fitness score per batch.
- Sits between the vector source (testbench/host FIFO) and each individual instance; one controller per instance.

---
 rtl/individual_eval_ctrl_if.sv | 47 ++++
 rtl/individual_eval_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/individual_eval_ctrl_if.sv
// Stream bundle between a vector source/result consumer and one
// individual_eval_ctrl.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid and ready are both 1. While valid is 1 and ready is 0, the
// sender holds valid and its payload stable. Ready may depend on state but
// never on valid.
//
// Signals:
//   in_valid/in_ready  vector stream (source -> controller)
//   in_a1..in_b0       operand words
//   in_exp             expected {y3,y2,y1,y0}, y3 in the MSBs
//   in_last            final vector of the batch
//   res_valid/res_ready result stream (controller -> consumer)
//   res_score          matching output words in the batch
//   res_perfect        vectors with all four words matching
//   res_count          vectors evaluated in the batch
//
// Modports: master = source/consumer side, slave = controller side.
interface individual_eval_ctrl_if #(
  parameter int W     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a1;
  logic [W-1:0]     in_a0;
  logic [W-1:0]     in_b1;
  logic [W-1:0]     in_b0;
  logic [4*W-1:0]   in_exp;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_score;
  logic [CNT_W-1:0] res_perfect;
  logic [CNT_W-1:0] res_count;

  modport master (
    output in_valid, in_a1, in_a0, in_b1, in_b0, in_exp, in_last, res_ready,
    input  in_ready, res_valid, res_score, res_perfect, res_count
  );

  modport slave (
    input  in_valid, in_a1, in_a0, in_b1, in_b0, in_exp, in_last, res_ready,
    output in_ready, res_valid, res_score, res_perfect, res_count
  );
endinterface

// File: rtl/individual_eval_ctrl.sv
// Fitness-evaluation sequencer for one combinational evolved individual.
//
// A vector (four operand words plus the four expected result words) is
// accepted in IDLE, driven onto the individual from registers, held for
// SETTLE cycles, and then the individual's four result words are compared
// against the expected words. Matches accumulate into a per-batch score;
// the batch closes on the vector flagged last and the totals are offered on
// the result stream until taken.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   host            slave side of individual_eval_ctrl_if (vector in,
//                   batch result out)
//   dut_a1..dut_b0  registered operands to the individual; change only on
//                   vector accept
//   dut_y3..dut_y0  individual results
//   busy            controller is not idle
//   state_dbg       current FSM state encoding (0 idle, 1 settle, 2 result)
//
// Parameters:
//   W       operand/result word width
//   SETTLE  cycles operands are held before outputs are sampled (1..15)
//   CNT_W   width of score and vector counters; all counters saturate
module individual_eval_ctrl #(
  parameter int W      = 16,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  individual_eval_ctrl_if.slave host,
  output logic [W-1:0]          dut_a1,
  output logic [W-1:0]          dut_a0,
  output logic [W-1:0]          dut_b1,
  output logic [W-1:0]          dut_b0,
  input  logic [W-1:0]          dut_y3,
  input  logic [W-1:0]          dut_y2,
  input  logic [W-1:0]          dut_y1,
  input  logic [W-1:0]          dut_y0,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [4*W-1:0]   exp_q;
  logic             last_q;
  logic [CNT_W-1:0] score;
  logic [CNT_W-1:0] perfect;
  logic [CNT_W-1:0] count;

  // Word-by-word comparison of the individual's outputs against the
  // expected register; only consumed in the last settle cycle.
  logic [3:0] word_eq;
  logic [2:0] hits;
  logic       all_hit;

  assign word_eq[3] = (dut_y3 == exp_q[4*W-1:3*W]);
  assign word_eq[2] = (dut_y2 == exp_q[3*W-1:2*W]);
  assign word_eq[1] = (dut_y1 == exp_q[2*W-1:W]);
  assign word_eq[0] = (dut_y0 == exp_q[W-1:0]);
  assign hits       = 3'(word_eq[3]) + 3'(word_eq[2]) +
                      3'(word_eq[1]) + 3'(word_eq[0]);
  assign all_hit    = &word_eq;

  // Saturating accumulators. The score sum is widened by three bits so a
  // 0..4 increment can never wrap before the clamp is applied.
  logic [CNT_W+2:0] score_sum;
  logic [CNT_W-1:0] score_next;
  logic [CNT_W-1:0] perfect_next;
  logic [CNT_W-1:0] count_next;

  assign score_sum    = (CNT_W+3)'(score) + (CNT_W+3)'(hits);
  assign score_next   = (score_sum > (CNT_W+3)'(CNT_MAX)) ? CNT_MAX
                                                          : score_sum[CNT_W-1:0];
  assign perfect_next = (!all_hit || perfect == CNT_MAX) ? perfect
                                                         : perfect + 1'b1;
  assign count_next   = (count == CNT_MAX) ? count : count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      exp_q      <= '0;
      last_q     <= 1'b0;
      dut_a1     <= '0;
      dut_a0     <= '0;
      dut_b1     <= '0;
      dut_b0     <= '0;
      score      <= '0;
      perfect    <= '0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone is the accept.
          if (host.in_valid) begin
            dut_a1     <= host.in_a1;
            dut_a0     <= host.in_a0;
            dut_b1     <= host.in_b1;
            dut_b0     <= host.in_b0;
            exp_q      <= host.in_exp;
            last_q     <= host.in_last;
            settle_cnt <= SETTLE_LOAD;
            // First vector of a batch: previous batch totals are dropped
            // here rather than at result handoff so they stay readable.
            if (count == '0) begin
              score   <= '0;
              perfect <= '0;
            end
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            score   <= score_next;
            perfect <= perfect_next;
            count   <= count_next;
            state   <= last_q ? S_RESULT : S_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        S_RESULT: begin
          if (host.res_ready) begin
            count <= '0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.in_ready    = (state == S_IDLE);
  assign host.res_valid   = (state == S_RESULT);
  assign host.res_score   = score;
  assign host.res_perfect = perfect;
  assign host.res_count   = count;
  assign busy             = (state != S_IDLE);
  assign state_dbg        = state;

endmodule
